// File: rtl/sd_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_pkg
// Description : Shared FSM encoding, frame geometry and CRC7 step function
//               for the SD CMD-line responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX    = 3'd1,
        ST_CHECK = 3'd2,
        ST_WAIT  = 3'd3,
        ST_TX    = 3'd4
    } state_t;

    localparam int CMD_FRAME_LEN = 48;
    localparam int CRC_SPAN      = 40;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int POS_START    = 47;
    localparam int POS_TX_BIT   = 46;
    localparam int POS_INDEX_HI = 45;
    localparam int POS_INDEX_LO = 40;
    localparam int POS_ARG_HI   = 39;
    localparam int POS_ARG_LO   = 8;
    localparam int POS_CRC_HI   = 7;
    localparam int POS_CRC_LO   = 1;
    localparam int POS_END      = 0;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_card_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_card_cmd_responder_if
// Description : CMD-line and card-side signal bundle of the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_card_cmd_responder_if;
    logic        cmd_from_host;
    logic        resp_en;
    logic [31:0] card_status;
    logic        cmd_to_host;
    logic        cmd_to_host_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        frame_error;
    logic        busy;

    modport slave (
        input  cmd_from_host, resp_en, card_status,
        output cmd_to_host, cmd_to_host_oe, cmd_valid, cmd_index, cmd_arg,
               frame_error, busy
    );

    modport master (
        output cmd_from_host, resp_en, card_status,
        input  cmd_to_host, cmd_to_host_oe, cmd_valid, cmd_index, cmd_arg,
               frame_error, busy
    );
endinterface
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc7
// Description : Serial CRC7 (x^7+x^3+1), zero init, one bit per enabled clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  wire logic       CLK,
    input  wire logic       rst_L,
    input  wire logic       clr,
    input  wire logic       en,
    input  wire logic       din,
    output logic [6:0]      crc
);

    logic [6:0] r_crc;

    always_ff @(posedge CLK or negedge rst_L) begin
        if (!rst_L) begin
            r_crc <= 7'h00;
        end else if (clr) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= crc7_step(r_crc, din);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_card_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_card_cmd_responder
// Description : Card-side CMD endpoint: receives and checks 48-bit commands,
//               answers with an R1-format frame after an NCR gap.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_card_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR = 2
) (
    input  wire logic             CLK,
    input  wire logic             rst_L,
    sd_card_cmd_responder_if.slave bus
);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_bit_cnt;
    logic [6:0]  r_ncr_cnt;
    logic [45:0] r_rx_shift;
    logic [39:0] r_tx_data;
    logic        r_cmd_to_host;
    logic        r_oe;
    logic        r_cmd_valid;
    logic        r_frame_error;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;

    logic [6:0]  w_crc;
    logic        w_crc_clr;
    logic        w_crc_en;
    logic        w_crc_din;
    logic        w_good;
    logic        w_tx_drive;
    logic [5:0]  w_tx_idx;
    logic        w_tx_bit;

    // Shift register holds frame bits 46..1 while the end bit is on the line,
    // so frame bit k sits at position k-1 at decision time.
    assign w_good = r_rx_shift[POS_TX_BIT-1] && bus.cmd_from_host &&
                    (r_rx_shift[POS_CRC_HI-1:POS_CRC_LO-1] == w_crc);

    assign w_tx_drive = ((r_state == ST_WAIT) && (r_ncr_cnt == 7'd0)) ||
                        ((r_state == ST_TX) && (r_bit_cnt != 6'd0));
    assign w_tx_idx   = (r_state == ST_WAIT) ? 6'd47 : (r_bit_cnt - 6'd1);

    always_comb begin
        w_tx_bit = 1'b1;
        if (w_tx_idx >= 6'd8) begin
            w_tx_bit = r_tx_data[w_tx_idx - 6'd8];
        end else if (w_tx_idx != 6'd0) begin
            w_tx_bit = w_crc[w_tx_idx[2:0] - 3'd1];
        end
    end

    // One CRC engine serves both directions; RX and TX never overlap.
    assign w_crc_clr = (r_state == ST_IDLE) || (r_state == ST_CHECK);
    assign w_crc_en  = ((r_state == ST_RX) && (r_bit_cnt >= 6'd9)) ||
                       (w_tx_drive && (w_tx_idx >= 6'd8));
    assign w_crc_din = (r_state == ST_RX) ? bus.cmd_from_host : w_tx_bit;

    sd_crc7 u_crc7 (
        .CLK   (CLK),
        .rst_L (rst_L),
        .clr   (w_crc_clr),
        .en    (w_crc_en),
        .din   (w_crc_din),
        .crc   (w_crc)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (!bus.cmd_from_host)            w_next = ST_RX;
            ST_RX:    if (r_bit_cnt == 6'd1)             w_next = ST_CHECK;
            ST_CHECK: w_next = (r_cmd_valid && bus.resp_en) ? ST_WAIT : ST_IDLE;
            ST_WAIT:  if (r_ncr_cnt == 7'd0)             w_next = ST_TX;
            ST_TX:    if (r_bit_cnt == 6'd0)             w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_L) begin
        if (!rst_L) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 6'd0;
            r_ncr_cnt     <= 7'd0;
            r_rx_shift    <= '0;
            r_tx_data     <= '0;
            r_cmd_to_host <= 1'b1;
            r_oe          <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_frame_error <= 1'b0;
            r_cmd_index   <= 6'd0;
            r_cmd_arg     <= 32'd0;
        end else begin
            r_state       <= w_next;
            r_cmd_valid   <= 1'b0;
            r_frame_error <= 1'b0;
            r_oe          <= w_tx_drive;
            r_cmd_to_host <= w_tx_drive ? w_tx_bit : 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    r_rx_shift <= {r_rx_shift[44:0], bus.cmd_from_host};
                    if (!bus.cmd_from_host) r_bit_cnt <= 6'd47;
                end
                ST_RX: begin
                    r_rx_shift <= {r_rx_shift[44:0], bus.cmd_from_host};
                    r_bit_cnt  <= r_bit_cnt - 6'd1;
                    if (r_bit_cnt == 6'd1) begin
                        if (w_good) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_index <= r_rx_shift[POS_INDEX_HI-1:POS_INDEX_LO-1];
                            r_cmd_arg   <= r_rx_shift[POS_ARG_HI-1:POS_ARG_LO-1];
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (r_cmd_valid) begin
                        r_tx_data <= {2'b00, r_cmd_index, bus.card_status};
                        r_ncr_cnt <= 7'(NCR - 2);
                    end
                end
                ST_WAIT: begin
                    if (r_ncr_cnt == 7'd0) r_bit_cnt <= 6'd47;
                    else                   r_ncr_cnt <= r_ncr_cnt - 7'd1;
                end
                ST_TX: begin
                    if (r_bit_cnt != 6'd0) r_bit_cnt <= r_bit_cnt - 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_to_host    = r_cmd_to_host;
    assign bus.cmd_to_host_oe = r_oe;
    assign bus.cmd_valid      = r_cmd_valid;
    assign bus.cmd_index      = r_cmd_index;
    assign bus.cmd_arg        = r_cmd_arg;
    assign bus.frame_error    = r_frame_error;
    assign bus.busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_card_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_card_cmd_responder
// Description : Scoreboard bench for two responders (NCR=2 and NCR=64).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sd_card_cmd_responder;

    typedef struct packed {
        logic        good;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [31:0] cyc;
        logic        resp;
        logic [47:0] rframe;
    } ev_t;

    typedef struct packed {
        logic [47:0] frame;
        logic [31:0] start;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        rst_L = 1'b0;
    logic [1:0]  host_line = 2'b11;
    logic        resp_en = 1'b0;
    logic [31:0] card_status = 32'd0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    ev_t         q_ev[2][$];
    rsp_t        q_rsp[2][$];
    logic [47:0] cap[2];
    int          cap_n[2];
    bit          busy_chk[2];
    logic [5:0]  exp_idx[2];
    logic [31:0] exp_arg[2];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sd_card_cmd_responder_if bus0();
    sd_card_cmd_responder_if bus1();

    assign bus0.cmd_from_host = host_line[0];
    assign bus0.resp_en       = resp_en;
    assign bus0.card_status   = card_status;
    assign bus1.cmd_from_host = host_line[1];
    assign bus1.resp_en       = resp_en;
    assign bus1.card_status   = card_status;

    sd_card_cmd_responder #(.NCR(2))  dut0 (.CLK(CLK), .rst_L(rst_L), .bus(bus0));
    sd_card_cmd_responder #(.NCR(64)) dut1 (.CLK(CLK), .rst_L(rst_L), .bus(bus1));

    function automatic int ncr_of(input int k);
        return (k == 0) ? 2 : 64;
    endfunction

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic [7:0] b0, input logic [31:0] arg);
        return {b0, arg, crc7({b0, arg}), 1'b1};
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic valid, input logic err, input logic [5:0] idx,
                       input logic [31:0] arg, input logic oe, input logic txb, input logic busy);
        ev_t  e;
        rsp_t r;
        if (!rst_L) begin
            cap_n[k]    = 0;
            busy_chk[k] = 0;
            return;
        end
        if (busy_chk[k]) begin
            busy_chk[k] = 0;
            chk("busy_after_error", k, busy, 0);
        end
        if (valid || err) begin
            n_cmp++;
            if (q_ev[k].size() == 0) begin
                n_bad++;
                $display("FAIL spurious_event dut%0d: got valid=%0b err=%0b expected none (cycle %0d)",
                         k, valid, err, cyc);
            end else begin
                e = q_ev[k].pop_front();
                chk("event_is_valid", k, valid, e.good);
                chk("event_cycle", k, cyc, e.cyc);
                chk("cmd_index", k, idx, e.idx);
                chk("cmd_arg", k, arg, e.arg);
                if (!valid) busy_chk[k] = 1;
                if (valid && e.resp) begin
                    r.frame = e.rframe;
                    r.start = e.cyc + ncr_of(k);
                    q_rsp[k].push_back(r);
                end
            end
        end
        if (oe) begin
            if (cap_n[k] == 0) begin
                n_cmp++;
                if (q_rsp[k].size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_response dut%0d: got oe=1 expected oe=0 (cycle %0d)", k, cyc);
                end else begin
                    chk("resp_start_cycle", k, cyc, q_rsp[k][0].start);
                end
            end
            cap[k]   = {cap[k][46:0], txb};
            cap_n[k] = cap_n[k] + 1;
        end else begin
            chk("idle_line_high", k, txb, 1);
            if (cap_n[k] != 0) begin
                chk("resp_oe_cycles", k, cap_n[k], 48);
                if (q_rsp[k].size() != 0) begin
                    r = q_rsp[k].pop_front();
                    chk("resp_frame", k, cap[k], r.frame);
                end
                cap_n[k] = 0;
            end
        end
    endtask

    always @(negedge CLK) begin
        mon(0, bus0.cmd_valid, bus0.frame_error, bus0.cmd_index, bus0.cmd_arg,
            bus0.cmd_to_host_oe, bus0.cmd_to_host, bus0.busy);
        mon(1, bus1.cmd_valid, bus1.frame_error, bus1.cmd_index, bus1.cmd_arg,
            bus1.cmd_to_host_oe, bus1.cmd_to_host, bus1.busy);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one frame; the expectation is queued while the end bit is on the line.
    task automatic send(input int k, input logic [47:0] f, input bit good, input bit resp,
                        input logic [31:0] status, output int e_cyc);
        ev_t e;
        resp_en     = resp;
        card_status = status;
        for (int i = 47; i >= 0; i--) begin
            tick(1);
            host_line[k] = f[i];
        end
        e_cyc = cyc;
        if (good) begin
            exp_idx[k] = f[45:40];
            exp_arg[k] = f[39:8];
        end
        e.good   = good;
        e.idx    = exp_idx[k];
        e.arg    = exp_arg[k];
        e.cyc    = e_cyc + 1;
        e.resp   = good && resp;
        e.rframe = mk_frame({2'b00, f[45:40]}, status);
        q_ev[k].push_back(e);
        tick(1);
        host_line[k] = 1'b1;
    endtask

    initial begin
        int e;
        int n;
        for (int k = 0; k < 2; k++) begin
            cap[k] = '0; cap_n[k] = 0; busy_chk[k] = 0; exp_idx[k] = '0; exp_arg[k] = '0;
        end
        tick(3);
        rst_L = 1'b1;
        @(negedge CLK);
        chk("reset_cmd_to_host", 0, bus0.cmd_to_host, 1);
        chk("reset_oe", 0, bus0.cmd_to_host_oe, 0);
        chk("reset_cmd_valid", 0, bus0.cmd_valid, 0);
        chk("reset_cmd_index", 0, bus0.cmd_index, 0);
        chk("reset_cmd_arg", 0, bus0.cmd_arg, 0);
        chk("reset_frame_error", 0, bus0.frame_error, 0);
        chk("reset_busy", 0, bus0.busy, 0);
        tick(3);

        send(0, 48'h40_0000_0000_95, 1, 0, 32'h0, e);          tick(10);  // CMD0, silent
        send(0, 48'h48_0000_01AA_87, 1, 1, 32'h0000_01AA, e);  tick(70);  // CMD8
        send(0, 48'h77_0000_0000_67, 0, 0, 32'h0, e);          tick(10);  // CMD55, CRC bit flipped
        send(0, 48'h77_0000_0000_65, 1, 0, 32'h0, e);          tick(10);  // CMD55 good
        send(0, mk_frame(8'h00, 32'h0), 0, 1, 32'h0, e);       tick(10);  // transmission bit 0
        send(0, 48'h40_0000_0000_94, 0, 1, 32'h0, e);          tick(10);  // end bit 0
        send(0, 48'h48_0000_01AA_87, 1, 1, 32'h1234_5678, e);  tick(70);

        // NCR=64 responder, with host start bits injected in WAIT and in TX
        send(1, 48'h48_0000_01AA_87, 1, 1, 32'h0000_0120, e);
        tick(9);  host_line[1] = 1'b0;
        tick(1);  host_line[1] = 1'b1;
        tick(69); host_line[1] = 1'b0;
        tick(1);  host_line[1] = 1'b1;
        tick(50);

        // Reset in the middle of a response
        send(0, 48'h48_0000_01AA_87, 1, 1, 32'hCAFE_F00D, e);
        n = 0;
        while (!bus0.cmd_to_host_oe && n < 200) begin
            tick(1);
            n++;
        end
        chk("resp_before_reset_oe", 0, bus0.cmd_to_host_oe, 1);
        tick(20);
        #2;
        rst_L = 1'b0;
        #1;
        chk("async_reset_oe", 0, bus0.cmd_to_host_oe, 0);
        chk("async_reset_line", 0, bus0.cmd_to_host, 1);
        chk("async_reset_busy", 0, bus0.busy, 0);
        chk("async_reset_index", 0, bus0.cmd_index, 0);
        chk("async_reset_arg", 0, bus0.cmd_arg, 0);
        q_rsp[0].delete();
        exp_idx[0] = '0;
        exp_arg[0] = '0;
        tick(1);
        rst_L = 1'b1;
        tick(3);
        send(0, 48'h40_0000_0000_95, 1, 0, 32'h0, e);
        tick(10);

        for (int k = 0; k < 2; k++) begin
            chk("events_outstanding", k, q_ev[k].size(), 0);
            chk("responses_outstanding", k, q_rsp[k].size(), 0);
            chk("oe_idle_at_end", k, cap_n[k], 0);
        end
        chk("final_busy0", 0, bus0.busy, 0);
        chk("final_busy1", 1, bus1.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_card_cmd_responder.md
# sd_card_cmd_responder

Card-side endpoint of the SD CMD line: deserializes 48-bit command tokens driven by the host's CMD block, checks framing and CRC7, presents index/argument to card-side logic, then serializes a 48-bit R1-format response after a programmable NCR gap. It sits opposite `CMD` in the SD host testbench and card model, clocked by the card clock. It closes the command loop for host-level simulation.

## Interface
- `NCR`, default 2: response gap in clocks, legal range 2..64.
- `CLK` input 1: card clock. All line sampling and driving occurs on the rising edge.
- `rst_L` input 1: asynchronous, active-low reset.
- `cmd_from_host` input 1: serial CMD line from host, idle high.
- `resp_en` input 1: sampled in the CHECK cycle. 1 = send response, 0 = silent (e.g. CMD0).
- `card_status` input 32: response payload, sampled in the CHECK cycle.
- `cmd_to_host` output 1: serial response bit. Reset value 1.
- `cmd_to_host_oe` output 1: high only while a response bit is driven. Reset value 0.
- `cmd_valid` output 1: one-cycle pulse on a good command. Reset value 0.
- `cmd_index` output 6: index of the last good command. Held until the next good command. Reset value 0.
- `cmd_arg` output 32: argument of the last good command. Held until the next good command. Reset value 0.
- `frame_error` output 1: one-cycle pulse on a bad CRC, bad transmission bit or bad end bit. Reset value 0.
- `busy` output 1: high in every state except IDLE. Reset value 0.

## Operation
- FSM states: IDLE, RX, CHECK, WAIT, TX.
- IDLE:
  - Sampling `cmd_from_host`=0 means the start bit has arrived. Load the bit counter with 47 and go to RX.
- RX:
  - Shift bits MSB first into a 48-bit register.
  - A serial CRC7 (x^7+x^3+1, init 0) runs over frame bits 47..8.
  - After the end bit (bit 0) is sampled, go to CHECK.
- CHECK (one cycle):
  - The frame is good when bit46=1, bit0=1 and received CRC[7:1] equals the computed CRC.
  - Good: pulse `cmd_valid`, update `cmd_index`/`cmd_arg`, latch `card_status` and `resp_en`. Go to WAIT if `resp_en`=1, else go to IDLE.
  - Bad: pulse `frame_error`, leave outputs unchanged, go to IDLE.
- WAIT:
  - Count NCR-1 further cycles, then go to TX.
- TX:
  - Drive 48 bits MSB first: 0, 0, echoed index[5:0], status[31:0], CRC7 over the preceding 40 bits, then 1.
  - `cmd_to_host_oe`=1 for exactly these 48 cycles. Return to IDLE.
- `cmd_from_host` is ignored in CHECK, WAIT and TX. A host start bit during those states is lost by design.
- When `cmd_to_host_oe`=0, `cmd_to_host` is 1.

## Timing
- Let E be the cycle in which the end bit is on the line. Then:
  - CHECK and the `cmd_valid`/`frame_error` pulse occur in E+1.
  - The response start bit is driven in E+1+NCR.
  - The response end bit is driven in E+NCR+48.
  - The first cycle at which IDLE can detect a new start bit is E+NCR+49.
- Outputs are registered.
- `cmd_index`/`cmd_arg` change in the same cycle `cmd_valid` is high.
- Reset asserted at any time, including mid-RX or mid-TX, immediately returns all outputs to their reset values and the FSM to IDLE. No partial frame is reported after reset is released.
- A frame with a start bit but no end bit stays in RX until reset. The host's timeout covers this case; no internal watchdog is provided.

## Structure
- Shared package `sd_cmd_pkg` holds:
  - FSM state encoding.
  - `CMD_FRAME_LEN`=48 and `CRC_SPAN`=40.
  - The CRC7 polynomial 7'h09.
  - Frame bit-position constants.
- Sub-module `sd_crc7`: serial CRC7 with `clr`, `en`, `din` and a 7-bit `crc` output.
  - Two instances, one for RX check and one for TX generation, or a single shared instance, since RX and TX never overlap.
- Counters:
  - 6-bit bit counter.
  - 7-bit NCR counter.

## Test plan
- CMD0 frame 0x40_00000000_95 with `resp_en`=0 -> `cmd_valid` pulse, `cmd_index`=0, `cmd_arg`=0, `cmd_to_host_oe` never rises.
- CMD8 frame 0x48_000001AA_87 with `resp_en`=1, `card_status`=0x000001AA, NCR=2 -> `cmd_index`=8, `cmd_arg`=0x1AA. Start bit appears at E+3. Decoded response is 0x08_000001AA_xx with a valid CRC7 and end bit 1; `oe` is high for exactly 48 cycles.
- CMD55 frame 0x77_00000000_65 with one CRC bit flipped -> `frame_error` pulse at E+1, no `cmd_valid`, `cmd_index`/`cmd_arg` keep their previous values, no response.
- Frame with transmission bit 0, or with end bit 0 -> `frame_error` pulse, FSM back in IDLE, `busy` low at E+2.
- NCR=64 with a CMD8 frame -> response start bit at exactly E+65. Host start bits injected during WAIT/TX are ignored.
- `rst_L` pulsed low at response bit 20 -> `oe`=0 and `cmd_to_host`=1 asynchronously. A following CMD0 frame is then received normally.
